// File: rtl/adc_volt_disp.sv
// Captures ADC samples on cs_n rising edge, scales to millivolts, converts to BCD,
// and drives a 4-digit multiplexed common-anode 7-segment display as X.XXX V.
module adc_volt_disp #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic [7:0]  data,
  output logic [12:0] mv,
  output logic [15:0] bcd,
  output logic        upd,
  output logic [3:0]  sel,
  output logic [7:0]  seg
);

  localparam int unsigned SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned ACC_W    = 21;
  localparam int unsigned FULL_MV  = 5000;

  typedef enum logic [1:0] {IDLE, MUL, BCD, LOAD} state_t;

  state_t             state, state_next;
  logic               cs_n_d;
  logic               start;
  logic [7:0]         operand;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   addend;
  logic [3:0]         cnt;
  logic [15:0]        dd, dd_adj;
  logic [4:0]         bit_idx;
  logic [SW-1:0]      scan;
  logic [1:0]         idx, idx_next;
  logic [3:0]         nib;

  function automatic logic [6:0] font(input logic [3:0] d);
    case (d)
      4'd0:    font = 7'h40;
      4'd1:    font = 7'h79;
      4'd2:    font = 7'h24;
      4'd3:    font = 7'h30;
      4'd4:    font = 7'h19;
      4'd5:    font = 7'h12;
      4'd6:    font = 7'h02;
      4'd7:    font = 7'h78;
      4'd8:    font = 7'h00;
      4'd9:    font = 7'h10;
      default: font = 7'h7F;
    endcase
  endfunction

  assign start = cs_n & ~cs_n_d & (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = MUL;
      MUL:     if (cnt == 4'd7) state_next = BCD;
      BCD:     if (cnt == 4'd12) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift-add partial product and add-3 adjustment for double-dabble
  always_comb begin
    addend  = operand[cnt[2:0]] ? (ACC_W'(FULL_MV) << cnt[2:0]) : '0;
    bit_idx = 5'd20 - {1'b0, cnt};
    dd_adj  = dd;
    for (int i = 0; i < 4; i++) begin
      if (dd[4*i +: 4] >= 4'd5) dd_adj[4*i +: 4] = dd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_d  <= 1'b1;
      operand <= '0;
      acc     <= '0;
      cnt     <= '0;
      dd      <= '0;
      mv      <= '0;
      bcd     <= '0;
      upd     <= 1'b0;
    end else begin
      cs_n_d <= cs_n;
      upd    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            operand <= data;
            acc     <= '0;
            cnt     <= '0;
          end
        end
        MUL: begin
          acc <= acc + addend;
          if (cnt == 4'd7) begin
            cnt <= '0;
            dd  <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        BCD: begin
          dd  <= {dd_adj[14:0], acc[bit_idx]};
          cnt <= cnt + 4'd1;
        end
        LOAD: begin
          mv  <= acc[20:8];
          bcd <= dd;
          upd <= 1'b1;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Free-running digit scan; sel/seg update on the wrap edge
  always_comb begin
    idx_next = idx + 2'd1;
    nib      = bcd[{idx_next, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan <= '0;
      idx  <= 2'd3;
      sel  <= 4'hF;
      seg  <= 8'hFF;
    end else if (scan == SW'(SCAN_DIV - 1)) begin
      scan <= '0;
      idx  <= idx_next;
      sel  <= ~(4'b0001 << idx_next);
      seg  <= {(idx_next != 2'd3), font(nib)};
    end else begin
      scan <= scan + SW'(1);
    end
  end

endmodule

// File: tb/tb_adc_volt_disp.sv
// Directed self-checking bench for adc_volt_disp with a fast scan divider.
module tb_adc_volt_disp;

  logic        clk;
  logic        rst_n;
  logic        cs_n;
  logic [7:0]  data;
  logic [12:0] mv;
  logic [15:0] bcd;
  logic        upd;
  logic [3:0]  sel;
  logic [7:0]  seg;

  int pass_cnt = 0;
  int total    = 0;

  adc_volt_disp #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .data(data),
    .mv(mv), .bcd(bcd), .upd(upd), .sel(sel), .seg(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs_n = 1'b0; data = 8'd0;
    tick(); tick();
    total++;
    if ({mv, bcd, upd, sel, seg} !== {13'd0, 16'h0000, 1'b0, 4'hF, 8'hFF})
      $display("FAIL reset: mv=%0d bcd=%h upd=%b sel=%b seg=%h", mv, bcd, upd, sel, seg);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  // One cs_n pulse; expects upd exactly 23 cycles after the start cycle
  task automatic convert(input logic [7:0] d, input logic [12:0] em,
                         input logic [15:0] eb, input string name);
    int early;
    early = 0;
    data = d; cs_n = 1'b1;
    tick();
    cs_n = 1'b0;
    if (upd) early++;
    for (int i = 2; i <= 22; i++) begin
      tick();
      if (upd) early++;
    end
    total++;
    if (early != 0) $display("FAIL %s early_upd: got %0d pulses, want 0", name, early);
    else pass_cnt++;
    tick();
    total++;
    if (upd !== 1'b1) $display("FAIL %s upd_latency: upd=%b want 1", name, upd);
    else pass_cnt++;
    total++;
    if (mv !== em) $display("FAIL %s mv: got %0d want %0d", name, mv, em);
    else pass_cnt++;
    total++;
    if (bcd !== eb) $display("FAIL %s bcd: got %h want %h", name, bcd, eb);
    else pass_cnt++;
    tick();
    total++;
    if (upd !== 1'b0) $display("FAIL %s upd_width: upd=%b want 0", name, upd);
    else pass_cnt++;
  endtask

  // Sync to digit 0 then check four digits, four cycles each
  task automatic test_scan(input logic [31:0] segs, input string name);
    int n;
    logic [3:0] esel;
    logic [7:0] eseg;
    n = 0;
    while (sel == 4'b1110 && n < 40) begin tick(); n++; end
    while (sel != 4'b1110 && n < 40) begin tick(); n++; end
    total++;
    if (n >= 40) begin
      $display("FAIL %s scan_sync: sel=%b never reached 1110", name, sel);
      return;
    end
    pass_cnt++;
    for (int dgt = 0; dgt < 4; dgt++) begin
      esel = ~(4'b0001 << dgt);
      eseg = segs[8*dgt +: 8];
      for (int k = 0; k < 4; k++) begin
        total++;
        if (sel !== esel || seg !== eseg)
          $display("FAIL %s digit%0d cyc%0d: sel=%b seg=%h want sel=%b seg=%h",
                   name, dgt, k, sel, seg, esel, eseg);
        else pass_cnt++;
        tick();
      end
    end
  endtask

  task automatic test_zero();
    convert(8'd0, 13'd0, 16'h0000, "zero");
    test_scan({8'h40, 8'hC0, 8'hC0, 8'hC0}, "scan_zero");
  endtask

  task automatic test_full_scale();
    convert(8'd255, 13'd4980, 16'h4980, "full");
    test_scan({8'h19, 8'h90, 8'h80, 8'hC0}, "scan_full");
  endtask

  task automatic test_values();
    convert(8'd128, 13'd2500, 16'h2500, "half");
    convert(8'd1,   13'd19,   16'h0019, "lsb");
    convert(8'd77,  13'd1503, 16'h1503, "v77");
    convert(8'd3,   13'd58,   16'h0058, "v3");
  endtask

  task automatic test_back_to_back();
    int ups;
    ups = 0;
    data = 8'd128; cs_n = 1'b1;
    tick();
    cs_n = 1'b0;
    for (int i = 2; i <= 10; i++) begin
      tick();
      if (upd) ups++;
    end
    data = 8'd200; cs_n = 1'b1;
    tick();
    cs_n = 1'b0;
    if (upd) ups++;
    for (int i = 12; i <= 22; i++) begin
      tick();
      if (upd) ups++;
    end
    tick();
    total++;
    if (upd !== 1'b1 || mv !== 13'd2500 || bcd !== 16'h2500)
      $display("FAIL b2b result: upd=%b mv=%0d bcd=%h want 1 2500 2500", upd, mv, bcd);
    else pass_cnt++;
    ups++;
    for (int i = 24; i <= 60; i++) begin
      tick();
      if (upd) ups++;
    end
    total++;
    if (ups != 1) $display("FAIL b2b upd_count: got %0d want 1", ups);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int ups;
    ups = 0;
    data = 8'd255; cs_n = 1'b1;
    tick();
    cs_n = 1'b0;
    for (int i = 2; i <= 12; i++) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if ({mv, bcd, upd, sel, seg} !== {13'd0, 16'h0000, 1'b0, 4'hF, 8'hFF})
      $display("FAIL abort_reset: mv=%0d bcd=%h upd=%b sel=%b seg=%h", mv, bcd, upd, sel, seg);
    else pass_cnt++;
    tick(); tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (upd) ups++;
    end
    total++;
    if (ups != 0 || mv !== 13'd0 || bcd !== 16'h0000)
      $display("FAIL abort_no_upd: ups=%0d mv=%0d bcd=%h want 0 0 0000", ups, mv, bcd);
    else pass_cnt++;
    convert(8'd1, 13'd19, 16'h0019, "after_abort");
  endtask

  initial begin
    test_reset();
    test_zero();
    test_full_scale();
    test_values();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
